// File: rtl/cnn_pkg.sv
// Shared types and helpers for the pooled/padded feature-map writer.
// Pure declarations and constant functions; no clocked logic.
// No flow control of its own.
package cnn_pkg;

  typedef logic [7:0] byte_t;

  // Writer state encoding.
  typedef logic [1:0] pp_state_t;
  localparam pp_state_t PP_IDLE  = 2'd0;
  localparam pp_state_t PP_CLEAR = 2'd1;
  localparam pp_state_t PP_RUN   = 2'd2;
  localparam pp_state_t PP_FIN   = 2'd3;

  // Unsigned byte maximum.
  function automatic byte_t max_u8(input byte_t a, input byte_t b);
    return (a > b) ? a : b;
  endfunction

  // Linear address of cell (c,y,x) in a channel-major H x W map.
  function automatic int unsigned fmap_addr(input int unsigned c, input int unsigned y,
                                            input int unsigned x, input int unsigned h,
                                            input int unsigned w);
    return c * h * w + y * w + x;
  endfunction

  // Bits needed to hold the value n (at least 1).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pool_pad_writer_if.sv
// Conv byte stream in, destination-RAM write port out.
// Stream carries no backpressure; ready only gates the upstream start.
// Write port is fire-and-forget, one byte per cycle at most.
interface pool_pad_writer_if import cnn_pkg::*; #(
  parameter int CHANNELS = 32,
  parameter int IN_W     = 28,
  parameter int IN_H     = 28,
  parameter int PAD      = 1
);
  localparam int OUT_W  = IN_W / 2 + 2 * PAD;
  localparam int OUT_H  = IN_H / 2 + 2 * PAD;
  localparam int ADDR_W = $clog2(CHANNELS * OUT_H * OUT_W);

  byte_t             in_data;
  logic              in_valid;
  logic              ready;
  byte_t             wr_data;
  logic              wr_we;
  logic [ADDR_W-1:0] wr_addr;

  // Environment side: drives the stream, observes the RAM port.
  modport master (output in_data, output in_valid,
                  input ready, input wr_data, input wr_we, input wr_addr);
  // Writer side.
  modport slave  (input in_data, input in_valid,
                  output ready, output wr_data, output wr_we, output wr_addr);
endinterface

// File: rtl/pool_line_buffer.sv
// Half-row store of horizontal pair maxima from the even pooling row.
// Read is combinational; write lands on the clock edge.
// No flow control; the caller never reads and writes one entry in the same cycle.
module pool_line_buffer import cnn_pkg::*; #(
  parameter int DEPTH = 14,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  byte_t         wdata,
  input  logic [AW-1:0] raddr,
  output byte_t         rdata
);

  byte_t mem [DEPTH];

  // Contents are don't-care after reset, so the array is never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pool_pad_writer.sv
// 2x2/2 max-pool of a conv byte stream into a zero-bordered destination map.
// Border clear: one write per cycle; pooled write lands 1 cycle after its accepting edge.
// No backpressure: ready is high only in RUN; samples outside RUN are dropped and flagged.
module pool_pad_writer import cnn_pkg::*; #(
  parameter int CHANNELS = 32,
  parameter int IN_W     = 28,
  parameter int IN_H     = 28,
  parameter int PAD      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  pool_pad_writer_if.slave bus
);

  localparam int OUT_W  = IN_W / 2 + 2 * PAD;
  localparam int OUT_H  = IN_H / 2 + 2 * PAD;
  localparam int ADDR_W = $clog2(CHANNELS * OUT_H * OUT_W);
  localparam int HALF_W = IN_W / 2;

  // Counters are shared by the border walk and the stream walk, so they
  // are sized for whichever of the two geometries is larger.
  localparam int CW  = cnt_w(CHANNELS);
  localparam int RW  = cnt_w((IN_H > OUT_H) ? IN_H : OUT_H);
  localparam int XW  = cnt_w((IN_W > OUT_W) ? IN_W : OUT_W);
  localparam int LAW = cnt_w(HALF_W - 1);

  localparam logic [CW-1:0] CH_LAST    = CW'(CHANNELS - 1);
  localparam logic [RW-1:0] CLR_Y_LAST = RW'(OUT_H - 1);
  localparam logic [RW-1:0] Y_PAD      = RW'(PAD);
  localparam logic [RW-1:0] Y_BOT      = RW'(OUT_H - PAD);
  localparam logic [XW-1:0] CLR_X_LAST = XW'(OUT_W - 1);
  localparam logic [XW-1:0] X_PAD_M1   = XW'(PAD - 1);
  localparam logic [XW-1:0] X_RIGHT    = XW'(OUT_W - PAD);
  localparam logic [RW-1:0] RUN_Y_LAST = RW'(IN_H - 1);
  localparam logic [XW-1:0] RUN_X_LAST = XW'(IN_W - 1);
  localparam logic [RW-1:0] Y_LIM      = RW'(2 * (IN_H / 2));
  localparam logic [XW-1:0] X_LIM      = XW'(2 * (IN_W / 2));

  pp_state_t         state;
  logic [CW-1:0]     ch_cnt;
  logic [RW-1:0]     row_cnt;
  logic [XW-1:0]     col_cnt;
  byte_t             hmax;
  logic              ready_q;
  byte_t             wr_data_q;
  logic              wr_we_q;
  logic [ADDR_W-1:0] wr_addr_q;

  // Border walk
  logic              clr_row_border;
  logic              clr_last;
  logic [CW-1:0]     clr_nx_ch;
  logic [RW-1:0]     clr_nx_row;
  logic [XW-1:0]     clr_nx_col;
  logic [ADDR_W-1:0] clr_addr;

  // Stream walk
  logic              accept;
  logic              in_win;
  logic              run_last;
  byte_t             hp;
  byte_t             lb_rdata;
  logic              lb_we;
  logic [LAW-1:0]    lb_idx;
  logic [ADDR_W-1:0] run_addr;

  assign clr_row_border = (row_cnt < Y_PAD) || (row_cnt >= Y_BOT);
  assign clr_addr = ADDR_W'(fmap_addr(32'(ch_cnt), 32'(row_cnt), 32'(col_cnt), OUT_H, OUT_W));

  // Next border cell: interior cells of a non-border row are jumped over in one step.
  always_comb begin
    clr_nx_ch  = ch_cnt;
    clr_nx_row = row_cnt;
    clr_nx_col = col_cnt + 1'b1;
    clr_last   = 1'b0;
    if (col_cnt == CLR_X_LAST) begin
      clr_nx_col = '0;
      if (row_cnt == CLR_Y_LAST) begin
        clr_nx_row = '0;
        if (ch_cnt == CH_LAST) clr_last = 1'b1;
        else                   clr_nx_ch = ch_cnt + 1'b1;
      end else begin
        clr_nx_row = row_cnt + 1'b1;
      end
    end else if (!clr_row_border && (col_cnt == X_PAD_M1)) begin
      clr_nx_col = X_RIGHT;
    end
  end

  assign accept   = bus.in_valid && (state == PP_RUN);
  assign in_win   = (row_cnt < Y_LIM) && (col_cnt < X_LIM);
  assign run_last = (ch_cnt == CH_LAST) && (row_cnt == RUN_Y_LAST) && (col_cnt == RUN_X_LAST);
  assign hp       = max_u8(hmax, bus.in_data);
  assign lb_idx   = LAW'(col_cnt >> 1);
  assign lb_we    = !rst && accept && in_win && col_cnt[0] && !row_cnt[0];
  assign run_addr = ADDR_W'(fmap_addr(32'(ch_cnt), 32'(row_cnt >> 1) + PAD,
                                      32'(col_cnt >> 1) + PAD, OUT_H, OUT_W));

  pool_line_buffer #(
    .DEPTH (HALF_W),
    .AW    (LAW)
  ) u_lb (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_idx),
    .wdata (hp),
    .raddr (lb_idx),
    .rdata (lb_rdata)
  );

  // Frame control, border clear, pooling and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PP_IDLE;
      ch_cnt    <= '0;
      row_cnt   <= '0;
      col_cnt   <= '0;
      hmax      <= '0;
      ready_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      wr_data_q <= '0;
      wr_we_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      wr_we_q <= 1'b0;
      done    <= 1'b0;
      case (state)
        PP_IDLE: begin
          if (start) begin
            state   <= PP_CLEAR;
            busy    <= 1'b1;
            overrun <= 1'b0;
            ch_cnt  <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
          end else if (bus.in_valid) begin
            overrun <= 1'b1;
          end
        end
        PP_CLEAR: begin
          if (bus.in_valid) overrun <= 1'b1;
          wr_we_q   <= 1'b1;
          wr_data_q <= '0;
          wr_addr_q <= clr_addr;
          if (clr_last) begin
            state   <= PP_RUN;
            ready_q <= 1'b1;
            ch_cnt  <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
          end else begin
            ch_cnt  <= clr_nx_ch;
            row_cnt <= clr_nx_row;
            col_cnt <= clr_nx_col;
          end
        end
        PP_RUN: begin
          if (accept) begin
            if (in_win) begin
              if (!col_cnt[0]) begin
                hmax <= bus.in_data;
              end else if (row_cnt[0]) begin
                wr_we_q   <= 1'b1;
                wr_data_q <= max_u8(lb_rdata, hp);
                wr_addr_q <= run_addr;
              end
            end
            if (run_last) begin
              state   <= PP_FIN;
              ready_q <= 1'b0;
              ch_cnt  <= '0;
              row_cnt <= '0;
              col_cnt <= '0;
            end else if (col_cnt == RUN_X_LAST) begin
              col_cnt <= '0;
              if (row_cnt == RUN_Y_LAST) begin
                row_cnt <= '0;
                ch_cnt  <= ch_cnt + 1'b1;
              end else begin
                row_cnt <= row_cnt + 1'b1;
              end
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
        PP_FIN: begin
          if (bus.in_valid) overrun <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= PP_IDLE;
        end
        default: state <= PP_IDLE;
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_we   = wr_we_q;
  assign bus.wr_addr = wr_addr_q;

endmodule

// File: doc/pool_pad_writer.md
Name: pool_pad_writer

Overview:
- Sits at the output side of a conv/ReLU layer and consumes its `conv_result`/`conv_valid` byte stream.
- Stream order: channel-major, then row, then col; no backpressure.
- Performs 2x2 stride-2 max pooling.
- Writes pooled bytes into the next layer's zero-padded input feature-map RAM through that layer's `data`/`we`/`addr` write port.
- Before accepting data, writes zeros to every border cell of every channel.

Parameters:
- CHANNELS, 32, number of feature-map channels in the stream.
- IN_W, 28, conv output width (unpadded).
- IN_H, 28, conv output height (unpadded).
- PAD, 1, zero border width in the destination map.
- OUT_W (localparam), IN_W/2 + 2*PAD, padded destination width.
- OUT_H (localparam), IN_H/2 + 2*PAD, padded destination height.
- ADDR_W (localparam), $clog2(CHANNELS*OUT_H*OUT_W), destination address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a frame; honoured only in IDLE.
- in_data  in  8  conv result byte.
- in_valid  in  1  in_data valid this cycle.
- ready  out  1  high in RUN; upstream conv start is gated on it.
- busy  out  1  high in CLEAR and RUN.
- done  out  1  one-cycle pulse at frame end.
- overrun  out  1  sticky: in_valid seen while ready=0; cleared by start or rst.
- wr_data  out  8  byte to destination RAM.
- wr_we  out  1  write enable.
- wr_addr  out  ADDR_W  destination address.

Behaviour:
- Reset (rst=1 at posedge, any state): state=IDLE; ready, busy, done, overrun, wr_we = 0; wr_data=0; wr_addr=0; all counters and hmax = 0. Line-buffer contents are don't-care.
- States: IDLE, CLEAR, RUN, FIN.
- IDLE:
  - start -> CLEAR, overrun<=0, channel/row/col counters = 0.
  - in_valid in IDLE sets overrun; the sample is dropped.
- CLEAR:
  - One border write per cycle: wr_we=1, wr_data=0.
  - Visit cells (c,y,x) with y<PAD or y>=OUT_H-PAD or x<PAD or x>=OUT_W-PAD, in c, y, x ascending order.
  - Address = c*OUT_H*OUT_W + y*OUT_W + x.
  - Total writes: CHANNELS*(OUT_H*OUT_W - (OUT_H-2*PAD)*(OUT_W-2*PAD)).
  - Interior cells are skipped without consuming a cycle.
  - After the final border write -> RUN; ready=1 from the next cycle.
  - in_valid during CLEAR sets overrun; the sample is dropped.
- RUN: each accepted sample at stream position (ch, r, c):
  - r>=2*(IN_H/2) or c>=2*(IN_W/2): discarded; the trailing odd row/col is floored away. Counters still advance.
  - c even: hmax<=in_data.
  - c odd: hp=max(hmax,in_data), unsigned compare.
    - r even: lb[c>>1]<=hp.
    - r odd: next cycle wr_we=1, wr_data=max(lb[c>>1],hp), wr_addr=ch*OUT_H*OUT_W + ((r>>1)+PAD)*OUT_W + (c>>1)+PAD.
  - Latency: exactly 1 cycle from the accepting edge to wr_we.
  - Line buffer lb has IN_W/2 entries.
  - Counters wrap col -> row -> channel.
  - Accepts in_valid every cycle (back-to-back supported).
- After the last sample (CHANNELS-1, IN_H-1, IN_W-1) is accepted:
  - The pending write, if any, completes.
  - Then FIN: done=1 for one cycle, ready=0, busy=0; -> IDLE.
- start outside IDLE is ignored.
- wr_we is low in every cycle with no write; wr_data/wr_addr hold their last value.
- rst mid-CLEAR or mid-RUN aborts the frame immediately; no further writes occur.

Decomposition:
- Shared package (cnn_pkg):
  - byte_t (8-bit unsigned).
  - function max_u8.
  - function fmap_addr(c,y,x,H,W).
  - state enum for this block.
- Natural sub-module: pool_line_buffer, an IN_W/2 x 8 register array with combinational read and a single write port. All other logic stays in the top.

Test Plan:
- CHANNELS=1, IN_W=IN_H=4, PAD=1, start -> 12 zero writes at addr 0,1,2,3,4,7,8,11,12,13,14,15 on consecutive cycles, then ready=1.
- Same config, back-to-back in_data=0..15 -> exactly 4 writes: addr5=5, addr6=7, addr9=13, addr10=15; then done pulse one cycle after the last write.
- IN_W=IN_H=5, data=0..24 -> writes addr5=6, addr6=8, addr9=16, addr10=18; col4 and row4 are never written.
- in_valid=1 during CLEAR -> overrun=1; no extra wr_we; a subsequent start clears overrun.
- CHANNELS=2, IN_W=IN_H=4, all samples 8'hFF -> channel-1 interior writes at addr 21,22,25,26 = 255; border of both channels (24 writes) = 0.
- Assert rst in the 3rd RUN sample cycle -> next cycle all outputs are 0 and state is IDLE; a fresh start reruns CLEAR fully.
